// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and defaults for the UART packet scheduler
package uart_pkg;

    // Top-level sequencing of one byte through the shared sender
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOCK,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    // Which part of the packet the next LOAD produces
    typedef enum logic [1:0] {
        PH_HDR,
        PH_PAY,
        PH_CHK
    } phase_t;

    localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;
    localparam int         TMO_DEFAULT      = 64;

    // Header byte carries the requester id in its low three bits
    function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [2:0] id);
        return base | {5'b00000, id};
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rtl/uart_tx_scheduler_rr_arbiter.sv - combinational N-way round-robin search
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Pick the requester closest after ptr, wrapping; ptr itself has lowest priority
    always_comb begin
        int best_d;
        int d;
        grant  = '0;
        idx    = '0;
        found  = 1'b0;
        best_d = N;
        d      = 0;
        for (int i = 0; i < N; i++) begin
            d = (i - int'(ptr) - 1 + 2 * N) % N;
            if (enable && req[i] && (d < best_d)) begin
                best_d = d;
                idx    = IW'(i);
                found  = 1'b1;
            end
        end
        if (found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin packet framer in front of the UART byte sender
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int         N_REQ    = 4,
    parameter logic [7:0] HDR_BASE = HDR_BASE_DEFAULT,
    parameter int         TMO      = TMO_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_REQ-1:0]     ReqValid,
    input  logic [8*N_REQ-1:0]   ReqData,
    input  logic [N_REQ-1:0]     ReqLast,
    output logic [N_REQ-1:0]     ReqReady,
    output logic [N_REQ-1:0]     Grant,
    output logic                 Busy,
    output logic                 TxErr,
    output logic [7:0]           TxData,
    output logic                 TxLock,
    input  logic                 TxAvail
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TMO + 1);

    state_t           state;
    phase_t           phase;
    logic [IW-1:0]    ptr;
    logic [2:0]       id;
    logic [7:0]       chk;
    logic             last_r;
    logic [1:0]       lock_cnt;
    logic [TW-1:0]    tmo_cnt;

    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0]    arb_idx;
    logic             arb_found;
    logic [7:0]       hdr;
    logic [7:0]       sel_data;
    logic             sel_valid;
    logic             sel_last;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req    (ReqValid),
        .ptr    (ptr),
        .enable (state == ST_IDLE),
        .grant  (arb_grant),
        .idx    (arb_idx),
        .found  (arb_found)
    );

    assign hdr = hdr_byte(HDR_BASE, id);

    // Route the granted requester's byte lane using the one-hot Grant register
    always_comb begin
        sel_data  = 8'h00;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (Grant[i]) begin
                sel_data  = ReqData[8*i +: 8];
                sel_valid = ReqValid[i];
                sel_last  = ReqLast[i];
            end
        end
    end

    // Ready is a handshake in the same cycle the payload byte is sampled
    assign ReqReady = (state == ST_LOAD && phase == PH_PAY && sel_valid) ? Grant : '0;

    // Packet sequencer: arbitration, framing, lock strobe and sender handshake
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            phase    <= PH_HDR;
            ptr      <= IW'(N_REQ - 1);
            id       <= 3'd0;
            chk      <= 8'h00;
            last_r   <= 1'b0;
            lock_cnt <= 2'd0;
            tmo_cnt  <= '0;
            Grant    <= '0;
            Busy     <= 1'b0;
            TxErr    <= 1'b0;
            TxData   <= 8'h00;
            TxLock   <= 1'b0;
        end else begin
            TxErr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        Grant <= arb_grant;
                        ptr   <= arb_idx;
                        id    <= 3'(arb_idx);
                        Busy  <= 1'b1;
                        phase <= PH_HDR;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    case (phase)
                        PH_HDR: begin
                            TxData   <= hdr;
                            chk      <= hdr;
                            lock_cnt <= 2'd0;
                            state    <= ST_LOCK;
                        end
                        PH_PAY: begin
                            // A missing payload byte stalls here indefinitely
                            if (sel_valid) begin
                                TxData   <= sel_data;
                                chk      <= chk ^ sel_data;
                                last_r   <= sel_last;
                                lock_cnt <= 2'd0;
                                state    <= ST_LOCK;
                            end
                        end
                        PH_CHK: begin
                            TxData   <= chk;
                            lock_cnt <= 2'd0;
                            state    <= ST_LOCK;
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
                ST_LOCK: begin
                    // TxData settles one cycle before the lock rises, then lock holds two cycles
                    if (lock_cnt == 2'd2) begin
                        TxLock  <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= ST_WAIT_BUSY;
                    end else begin
                        TxLock   <= 1'b1;
                        lock_cnt <= lock_cnt + 2'd1;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!TxAvail) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmo_cnt >= TW'(TMO - 1)) begin
                        tmo_cnt <= TW'(TMO);
                        TxErr   <= 1'b1;
                        Grant   <= '0;
                        Busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (TxAvail) begin
                        case (phase)
                            PH_HDR: begin
                                phase <= PH_PAY;
                                state <= ST_LOAD;
                            end
                            PH_PAY: begin
                                phase <= last_r ? PH_CHK : PH_PAY;
                                state <= ST_LOAD;
                            end
                            default: begin
                                Grant <= '0;
                                Busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    localparam int N    = 4;
    localparam int SEND = 20;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   ReqValid;
    logic [8*N-1:0] ReqData;
    logic [N-1:0]   ReqLast;
    logic [N-1:0]   ReqReady;
    logic [N-1:0]   Grant;
    logic           Busy;
    logic           TxErr;
    logic [7:0]     TxData;
    logic           TxLock;
    logic           TxAvail;

    uart_tx_scheduler #(
        .N_REQ    (N),
        .HDR_BASE (8'hA0),
        .TMO      (64)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ReqValid (ReqValid),
        .ReqData  (ReqData),
        .ReqLast  (ReqLast),
        .ReqReady (ReqReady),
        .Grant    (Grant),
        .Busy     (Busy),
        .TxErr    (TxErr),
        .TxData   (TxData),
        .TxLock   (TxLock),
        .TxAvail  (TxAvail)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // requester model: per-requester queue of {last, data}
    logic [8:0]   src_q [N][$];
    logic [N-1:0] hold = '0;
    logic [N-1:0] hs   = '0;
    int           readycnt [N];

    // logs from the monitor / sender model
    logic [7:0]   sent_q [$];
    int           lock_w_q [$];
    int           lock_rise_q [$];
    logic [N-1:0] grant_q [$];
    int           grant_rise_q [$];
    int           grant_drop_q [$];
    int           err_q [$];
    int           cyc = 0;
    int           lock_run = 0;
    int           busy_cnt = 0;
    int           grant_glitch = 0;
    logic         lock_prev = 1'b0;
    logic         stuck = 1'b0;
    logic [N-1:0] grant_prev = '0;
    logic [N-1:0] grant_at_err = '1;

    logic [7:0]   exp_b [$];
    logic [N-1:0] exp_g [$];

    initial TxAvail = 1'b1;

    // sender model, handshake counting and event logging
    always @(posedge CLK) begin
        cyc++;
        if (TxLock) lock_run++;
        else if (lock_run != 0) begin
            lock_w_q.push_back(lock_run);
            lock_run = 0;
        end
        if (TxLock && !lock_prev) begin
            lock_rise_q.push_back(cyc);
            if (TxAvail && busy_cnt == 0) begin
                sent_q.push_back(TxData);
                if (!stuck) begin
                    busy_cnt = SEND;
                    TxAvail <= 1'b0;
                end
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) TxAvail <= 1'b1;
        end
        lock_prev = TxLock;
        if (Grant != '0 && grant_prev == '0) begin
            grant_q.push_back(Grant);
            grant_rise_q.push_back(cyc);
        end
        if (Grant == '0 && grant_prev != '0) grant_drop_q.push_back(cyc);
        if (Grant != '0 && grant_prev != '0 && Grant != grant_prev) grant_glitch++;
        grant_prev = Grant;
        if (TxErr) begin
            err_q.push_back(cyc);
            grant_at_err = Grant;
        end
        for (int i = 0; i < N; i++) if (ReqValid[i] && ReqReady[i]) readycnt[i]++;
        hs <= ReqValid & ReqReady;
    end

    // requester drive on the falling edge
    always @(negedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            ReqValid[i]       = !hold[i] && (src_q[i].size() > 0);
            ReqData[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0][7:0] : 8'h00;
            ReqLast[i]        = (src_q[i].size() > 0) ? src_q[i][0][8] : 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int at_i(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    task automatic clear_logs();
        sent_q.delete(); lock_w_q.delete(); lock_rise_q.delete();
        grant_q.delete(); grant_rise_q.delete(); grant_drop_q.delete(); err_q.delete();
        grant_glitch = 0;
        grant_at_err = '1;
        for (int i = 0; i < N; i++) readycnt[i] = 0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (t < 3000 && !(all_empty() && !Busy && busy_cnt == 0)) begin
            tick(1);
            t++;
        end
        check({tag, "_done_in_time"}, 32'(t < 3000), 32'd1);
        tick(2);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nbytes"}, sent_q.size(), exp_b.size());
        for (int k = 0; k < exp_b.size(); k++)
            check($sformatf("%s_byte%0d", tag, k),
                  (k < sent_q.size()) ? 32'(sent_q[k]) : 32'hDEAD, 32'(exp_b[k]));
    endtask

    task automatic check_grants(input string tag);
        check({tag, "_ngrants"}, grant_q.size(), exp_g.size());
        for (int k = 0; k < exp_g.size(); k++)
            check($sformatf("%s_grant%0d", tag, k),
                  (k < grant_q.size()) ? 32'(grant_q[k]) : 32'hDEAD, 32'(exp_g[k]));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"},  32'(Grant),    32'd0);
        check({tag, "_busy"},   32'(Busy),     32'd0);
        check({tag, "_lock"},   32'(TxLock),   32'd0);
        check({tag, "_data"},   32'(TxData),   32'd0);
        check({tag, "_err"},    32'(TxErr),    32'd0);
        check({tag, "_ready"},  32'(ReqReady), 32'd0);
    endtask

    initial begin
        int t;
        int n0;
        RST = 1'b1;
        ReqValid = '0;
        ReqData  = '0;
        ReqLast  = '0;
        for (int i = 0; i < N; i++) readycnt[i] = 0;
        tick(3);
        check_outputs_zero("reset");
        RST = 1'b0;
        tick(2);

        // single packet from requester 1
        clear_logs();
        src_q[1].push_back({1'b0, 8'h12});
        src_q[1].push_back({1'b1, 8'h34});
        wait_done("single");
        exp_b = '{8'hA1, 8'h12, 8'h34, 8'h87};
        check_bytes("single");
        check("single_nlocks", lock_w_q.size(), 4);
        foreach (lock_w_q[k]) check($sformatf("single_lockw%0d", k), lock_w_q[k], 2);
        check("single_ready", readycnt[1], 2);
        exp_g = '{4'b0010};
        check_grants("single");
        check("single_glitch", grant_glitch, 0);
        check("single_lock_latency", at_i(lock_rise_q, 0) - at_i(grant_rise_q, 0), 2);

        // round robin among 0, 2, 3 from a fresh pointer
        RST = 1'b1; tick(2); RST = 1'b0;
        clear_logs();
        src_q[0].push_back({1'b1, 8'h50});
        src_q[0].push_back({1'b1, 8'h51});
        src_q[2].push_back({1'b1, 8'h52});
        src_q[3].push_back({1'b1, 8'h53});
        wait_done("rr");
        exp_g = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
        check_grants("rr");
        exp_b = '{8'hA0, 8'h50, 8'hF0, 8'hA2, 8'h52, 8'hF0,
                  8'hA3, 8'h53, 8'hF0, 8'hA0, 8'h51, 8'hF1};
        check_bytes("rr");

        // payload stall: requester 0 goes quiet after its first byte
        clear_logs();
        src_q[0].push_back({1'b0, 8'h11});
        t = 0;
        while (t < 500 && readycnt[0] < 1) begin tick(1); t++; end
        check("stall_first_taken", 32'(t < 500), 32'd1);
        tick(40);
        n0 = lock_rise_q.size();
        tick(60);
        check("stall_no_lock", lock_rise_q.size(), n0);
        check("stall_busy", 32'(Busy), 32'd1);
        check("stall_grant", 32'(Grant), 32'b0001);
        src_q[0].push_back({1'b1, 8'h22});
        wait_done("stall");
        exp_b = '{8'hA0, 8'h11, 8'h22, 8'h93};
        check_bytes("stall");

        // timeout: sender never leaves idle for the first header
        clear_logs();
        stuck = 1'b1;
        src_q[1].push_back({1'b1, 8'h77});
        src_q[2].push_back({1'b1, 8'h66});
        t = 0;
        while (t < 300 && err_q.size() == 0) begin tick(1); t++; end
        check("tmo_err_seen", 32'(t < 300), 32'd1);
        stuck = 1'b0;
        wait_done("tmo");
        check("tmo_err_count", err_q.size(), 1);
        check("tmo_err_delay", at_i(err_q, 0) - at_i(lock_rise_q, 0), 66);
        check("tmo_grant_cleared", 32'(grant_at_err), 32'd0);
        exp_g = '{4'b0010, 4'b0100, 4'b0010};
        check_grants("tmo");
        exp_b = '{8'hA1, 8'hA2, 8'h66, 8'hC4, 8'hA1, 8'h77, 8'hD6};
        check_bytes("tmo");

        // reset during WAIT_DONE of a payload byte
        clear_logs();
        src_q[0].push_back({1'b0, 8'h01});
        src_q[0].push_back({1'b1, 8'h02});
        t = 0;
        while (t < 500 && !(sent_q.size() >= 2 && TxAvail == 1'b0)) begin tick(1); t++; end
        check("mrst_reached_payload", 32'(t < 500), 32'd1);
        tick(3);
        hold[0] = 1'b1;
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        check_outputs_zero("mrst");
        tick(30);
        src_q[1].push_back({1'b1, 8'h0B});
        hold[0] = 1'b0;
        wait_done("mrst");
        exp_g = '{4'b0001, 4'b0001, 4'b0010};
        check_grants("mrst");
        exp_b = '{8'hA0, 8'h01, 8'hA0, 8'h02, 8'hA2, 8'hA1, 8'h0B, 8'hAA};
        check_bytes("mrst");

        // back-to-back packets from requester 2 alone
        clear_logs();
        src_q[2].push_back({1'b1, 8'h31});
        src_q[2].push_back({1'b1, 8'h32});
        wait_done("b2b");
        exp_g = '{4'b0100, 4'b0100};
        check_grants("b2b");
        exp_b = '{8'hA2, 8'h31, 8'h93, 8'hA2, 8'h32, 8'h90};
        check_bytes("b2b");
        check("b2b_regrant_gap", at_i(grant_rise_q, 1) - at_i(grant_drop_q, 0), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
